pipeline_controller: RTL and testbench
======================================

# pipeline_controller

- Sequences stall, freeze, flush and halt for the 5-stage RISC-V pipeline.
- Inputs:
  - the forwarding unit's load-use/branch-operand stall request
  - the ID-stage redirect
  - the data-memory handshake
  - the WB-stage halt
- Drives the PC and pipeline-register write/flush enables.
- Also keeps saturating stall/flush performance counters and a memory watchdog.

## Interface
- CNT_W, 16, width of stallCount/flushCount
- TO_W, 8, width of watchdog counter
- MEM_TIMEOUT, 8'd255, consecutive frozen memory cycles before forced halt (legal 2..2^TO_W-1)

- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- hazardStall  input  1  stall request from forwarding unit (nop)
- branchTaken  input  1  ID-stage redirect (taken branch, jal, jalr)
- memReq  input  1  MEM stage has a load/store this cycle
- memReady  input  1  data memory completes the access this cycle
- halt  input  1  ecall/ebreak reached WB
- counterClear  input  1  synchronous clear of both perf counters
- pcWrite  output  1  PC update enable
- IF_ID_write  output  1  IF/ID register enable
- IF_ID_flush  output  1  IF/ID to bubble
- ID_EX_flush  output  1  ID/EX to bubble
- EX_MEM_write  output  1  EX/MEM register enable
- MEM_WB_write  output  1  MEM/WB register enable
- halted  output  1  core stopped
- memTimeout  output  1  sticky, halt caused by watchdog
- stallCount  output  CNT_W  cycles with any stall or freeze
- flushCount  output  CNT_W  cycles with IF_ID_flush=1

## Operation

**States:** RUN, MEM_WAIT, HALTED.

**Control outputs** are combinational from state and inputs.

**Default (no event):** all writes 1, all flushes 0.

**RUN**, events in priority order:
1. halt=1: all writes 0, flushes 0; next HALTED. Suppresses all other events.
2. memReq=1 and memReady=0 (freeze): all writes 0, flushes 0; next MEM_WAIT; watchdog←1.
3. hazardStall=1: pcWrite=0, IF_ID_write=0, ID_EX_flush=1; other writes 1.
   - If branchTaken=1 in the same cycle, the stall wins and the branch is ignored; it is re-evaluated next cycle.
4. branchTaken=1: pcWrite=1, IF_ID_flush=1, all writes 1.

**MEM_WAIT:**
- memReady=0:
  - Full freeze (as in RUN item 2).
  - If watchdog==MEM_TIMEOUT-1: next HALTED, memTimeout←1.
  - Else: watchdog++.
- memReady=1:
  - Outputs as RUN with the memory condition false (items 1, 3 and 4 apply).
  - Next RUN, unless halt=1 (then HALTED).

**HALTED:**
- All writes 0, flushes 0, halted=1.
- Exit only via reset.

**Counters:**
- stallCount increments on any cycle with pcWrite=0 in RUN or MEM_WAIT.
- flushCount increments on any cycle with IF_ID_flush=1.
- Both saturate at 2^CNT_W-1 (no wrap).
- counterClear=1 forces 0 and overrides increment in the same cycle.
- Counters hold in HALTED.

## Timing
- Control outputs are valid in the same cycle as their inputs; zero latency.
- State, watchdog, memTimeout and counters update on the rising edge.
- A memory freeze lasts exactly until the first cycle with memReady=1. That cycle advances the pipeline.
- Watchdog: with memReady held low, HALTED is entered at the edge that ends the MEM_TIMEOUT-th consecutive frozen cycle (the RUN entry cycle counts as 1).
- **Reset values:**
  - state RUN, watchdog 0, memTimeout 0, stallCount 0, flushCount 0, halted 0.
  - While reset is high, all writes and flushes are 0.
- **Reset mid-operation** (MEM_WAIT or HALTED): immediate return to RUN with the reset values above; no pending stall survives.

## Structure
- Shared package (core pkg): state encoding (RUN=2'd0, MEM_WAIT=2'd1, HALTED=2'd2) and default MEM_TIMEOUT.
- One sub-module, sat_counter:
  - Parameter: width.
  - Ports: inc, clr, q.
  - Saturating; clr has priority.
  - Instantiated twice (stall and flush counters).
- FSM, watchdog and output decode stay in pipeline_controller.

## Test plan
- **Load-use stall:** hazardStall=1 for 1 cycle in RUN.
  - That cycle: pcWrite=0, IF_ID_write=0, ID_EX_flush=1, EX_MEM_write=1.
  - stallCount 0→1; state stays RUN.
- **Branch flush, and stall over branch:**
  - branchTaken=1 alone: IF_ID_flush=1, pcWrite=1; flushCount 0→1.
  - hazardStall=1 with branchTaken=1: IF_ID_flush=0, ID_EX_flush=1; flushCount unchanged.
- **Memory freeze:** memReq=1, memReady=0 for 3 cycles, then memReady=1.
  - All writes 0 for 3 cycles; state MEM_WAIT after the first edge.
  - 4th cycle all writes 1; back to RUN; stallCount=3.
- **Watchdog (MEM_TIMEOUT=4):** memReq=1, memReady=0 held.
  - Frozen 4 cycles; 5th cycle halted=1, memTimeout=1.
  - halt and memReady are ignored afterwards.
- **Halt and async reset:**
  - halt=1 during hazardStall=1: next cycle HALTED, all writes 0.
  - Assert reset mid-cycle: state RUN, counters 0 immediately, before the next clock edge.
- **Counter saturation and clear (CNT_W=2):**
  - 5 stall cycles: stallCount=3.
  - counterClear=1 with hazardStall=1: stallCount=0 next edge.

Source files
------------

// File: rtl/pipeline_controller_pkg.sv
// pipeline_controller_pkg: shared state encoding and default watchdog limit
package pipeline_controller_pkg;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_e;
    localparam int DEF_MEM_TIMEOUT = 255;
endpackage

// File: rtl/pipeline_controller_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_q, q_d;
    // next count: clear wins, otherwise count up until all ones
    always_comb begin
        q_d = clr ? '0 : (inc && q_q != '1) ? q_q + 1'b1 : q_q;
    end
    // count register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    end
    assign q = q_q;
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: stall/freeze/flush/halt sequencing for the 5-stage pipeline
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int              CNT_W       = 16,
    parameter int              TO_W        = 8,
    parameter logic [TO_W-1:0] MEM_TIMEOUT = TO_W'(DEF_MEM_TIMEOUT)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hazardStall,
    input  logic             branchTaken,
    input  logic             memReq,
    input  logic             memReady,
    input  logic             halt,
    input  logic             counterClear,
    output logic             pcWrite,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_write,
    output logic             MEM_WB_write,
    output logic             halted,
    output logic             memTimeout,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);
    state_e          st_q, st_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            mt_q, mt_d;
    logic            ev_halt, freeze, stop;
    // halt is only seen when WB can advance; a freeze holds until memReady
    always_comb begin
        ev_halt      = halt && (st_q == RUN || memReady);
        freeze       = !memReady && (st_q == MEM_WAIT || memReq);
        stop         = reset || st_q == HALTED || ev_halt || freeze;
        pcWrite      = !stop && !hazardStall;
        IF_ID_write  = !stop && !hazardStall;
        ID_EX_flush  = !stop && hazardStall;
        IF_ID_flush  = !stop && !hazardStall && branchTaken;
        EX_MEM_write = !stop;
        MEM_WB_write = !stop;
        st_d         = st_q;
        wd_d         = wd_q;
        mt_d         = mt_q;
        if (st_q == HALTED) begin
            st_d = HALTED;
        end else if (ev_halt) begin
            st_d = HALTED;
        end else if (freeze) begin
            if (st_q == RUN) begin
                st_d = MEM_WAIT;
                wd_d = TO_W'(1);
            end else if (wd_q == MEM_TIMEOUT - 1'b1) begin
                st_d = HALTED;
                mt_d = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end else begin
            st_d = RUN;
            wd_d = '0;
        end
    end
    // state, watchdog and sticky timeout flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_q <= RUN;
            wd_q <= '0;
            mt_q <= 1'b0;
        end else begin
            st_q <= st_d;
            wd_q <= wd_d;
            mt_q <= mt_d;
        end
    end
    assign halted     = st_q == HALTED;
    assign memTimeout = mt_q;
    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (st_q != HALTED && !pcWrite),
        .clr   (counterClear),
        .q     (stallCount)
    );
    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (IF_ID_flush),
        .clr   (counterClear),
        .q     (flushCount)
    );
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed vector table plus multi-cycle sequences
module tb_pipeline_controller;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       hazardStall = 1'b0, branchTaken = 1'b0, memReq = 1'b0;
    logic       memReady = 1'b0, halt = 1'b0, counterClear = 1'b0;
    logic       pcWrite, IF_ID_write, IF_ID_flush, ID_EX_flush;
    logic       EX_MEM_write, MEM_WB_write, halted, memTimeout;
    logic [1:0] stallCount, flushCount;
    logic [5:0] ctl;
    int         checks = 0;
    int         errors = 0;

    pipeline_controller #(.CNT_W(2), .TO_W(8), .MEM_TIMEOUT(8'd4)) dut (
        .clock(clock), .reset(reset), .hazardStall(hazardStall),
        .branchTaken(branchTaken), .memReq(memReq), .memReady(memReady),
        .halt(halt), .counterClear(counterClear), .pcWrite(pcWrite),
        .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .ID_EX_flush(ID_EX_flush), .EX_MEM_write(EX_MEM_write),
        .MEM_WB_write(MEM_WB_write), .halted(halted), .memTimeout(memTimeout),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    always #5 clock = ~clock;
    assign ctl = {pcWrite, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_write, MEM_WB_write};

    typedef struct {
        logic       hs, bt, mrq, mrd, hlt;
        logic [5:0] ctl;
        int         sc, fc;
        logic       h;
    } vec_t;
    vec_t v[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        {hazardStall, branchTaken, memReq, memReady, halt, counterClear} = '0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        v[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110011, 0, 0, 1'b0};
        v[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000111, 1, 0, 1'b0};
        v[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b111011, 0, 1, 1'b0};
        v[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000111, 1, 0, 1'b0};
        v[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000, 1, 0, 1'b1};
        v[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000000, 1, 0, 1'b0};
        v[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b110011, 0, 0, 1'b0};
        v[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000, 1, 0, 1'b1};
        v[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 1, 0, 1'b0};
        v[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b000000, 1, 0, 1'b1};
        #1;
        chk("reset_ctl", 32'(ctl), 0);
        chk("reset_halted", 32'(halted), 0);
        for (int i = 0; i < 10; i++) begin
            do_reset();
            {hazardStall, branchTaken, memReq, memReady, halt} = {v[i].hs, v[i].bt, v[i].mrq, v[i].mrd, v[i].hlt};
            #1;
            chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(v[i].ctl));
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(stallCount), v[i].sc);
            chk($sformatf("vec%0d_flush", i), 32'(flushCount), v[i].fc);
            chk($sformatf("vec%0d_halted", i), 32'(halted), 32'(v[i].h));
        end
        do_reset();
        memReq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("freeze_ctl", 32'(ctl), 0);
            @(posedge clock);
            #1;
            chk("freeze_state", 32'(dut.st_q), 1);
            @(negedge clock);
        end
        memReady = 1'b1;
        #1;
        chk("freeze_release_ctl", 32'(ctl), 32'(6'b110011));
        @(posedge clock);
        #1;
        chk("freeze_back_run", 32'(dut.st_q), 0);
        chk("freeze_stall_cnt", 32'(stallCount), 3);
        chk("freeze_no_timeout", 32'(memTimeout), 0);
        do_reset();
        memReq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wd_not_halted", 32'(halted), 0);
            chk("wd_frozen_ctl", 32'(ctl), 0);
            @(posedge clock);
            @(negedge clock);
        end
        #1;
        chk("wd_halted", 32'(halted), 1);
        chk("wd_timeout", 32'(memTimeout), 1);
        chk("wd_halted_ctl", 32'(ctl), 0);
        @(negedge clock);
        memReady = 1'b1;
        halt = 1'b1;
        @(posedge clock);
        @(negedge clock);
        #1;
        chk("wd_stays_halted", 32'(halted), 1);
        chk("wd_stays_ctl", 32'(ctl), 0);
        do_reset();
        branchTaken = 1'b1;
        repeat (2) @(negedge clock);
        branchTaken = 1'b0;
        #1;
        chk("pre_halt_flush", 32'(flushCount), 2);
        hazardStall = 1'b1;
        halt = 1'b1;
        #1;
        chk("halt_stall_ctl", 32'(ctl), 0);
        @(posedge clock);
        @(negedge clock);
        #1;
        chk("halt_halted", 32'(halted), 1);
        chk("halt_ctl", 32'(ctl), 0);
        chk("halt_stall_cnt", 32'(stallCount), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_halted", 32'(halted), 0);
        chk("areset_state", 32'(dut.st_q), 0);
        chk("areset_stall", 32'(stallCount), 0);
        chk("areset_flush", 32'(flushCount), 0);
        chk("areset_ctl", 32'(ctl), 0);
        @(negedge clock);
        reset = 1'b0;
        {hazardStall, halt} = '0;
        #1;
        chk("post_reset_ctl", 32'(ctl), 32'(6'b110011));
        do_reset();
        hazardStall = 1'b1;
        repeat (5) @(negedge clock);
        #1;
        chk("sat_stall", 32'(stallCount), 3);
        counterClear = 1'b1;
        @(posedge clock);
        #1;
        chk("clear_stall", 32'(stallCount), 0);
        @(negedge clock);
        counterClear = 1'b0;
        @(posedge clock);
        #1;
        chk("after_clear_stall", 32'(stallCount), 1);
        do_reset();
        branchTaken = 1'b1;
        repeat (4) @(negedge clock);
        #1;
        chk("sat_flush", 32'(flushCount), 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
